// File: rtl/mem_arbiter.sv
// mem_arbiter: byte-serial controller sharing one 8-bit synchronous RAM port
// between instruction fetch and load/store. MEM wins arbitration, accesses are
// sequenced one byte per cycle, little-endian, and a taken branch aborts a fetch.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data_o,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata_o,
  output logic              mem_done,
  input  logic              branch_flush_i,
  output logic              stall_if_o,
  output logic              stall_mem_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_dout_o,
  output logic              ram_wr_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, IF_RD = 2'd1, MEM_RD = 2'd2, MEM_WR = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d, len_q, len_d, cnt_inc, mem_len;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, buf_q, buf_d;
  logic [31:0]       if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic [7:0]        dout_q, dout_d;
  logic              wr_q, wr_d, if_done_q, if_done_d, mem_done_q, mem_done_d;
  logic              can_grant, grant_mem, grant_if, rd_last, wr_last;
  logic [7:0]        wbyte [4];

  // Byte lanes of the latched store data, selected by the byte counter.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wbyte
      assign wbyte[gi] = wdata_q[8*gi +: 8];
    end
  endgenerate

  // In read states cnt is the index of the address currently on the RAM port;
  // the extra count value N covers the final byte arriving from the sync RAM.
  assign cnt_inc   = cnt_q + 3'd1;
  assign can_grant = (state_q == IDLE) && !if_done_q && !mem_done_q;
  assign grant_mem = can_grant && mem_req;
  assign grant_if  = can_grant && !mem_req && if_req && !branch_flush_i;
  assign rd_last   = ((state_q == IF_RD) || (state_q == MEM_RD)) && (cnt_q == len_q);
  assign wr_last   = (state_q == MEM_WR) && (cnt_q == len_q - 3'd1);

  // Access length in bytes from the MEM size code (3 behaves as word).
  always_comb begin
    case (mem_size)
      2'd0:    mem_len = 3'd1;
      2'd1:    mem_len = 3'd2;
      default: mem_len = 3'd4;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      dout_q      <= '0;
      wr_q        <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      dout_q      <= dout_d;
      wr_q        <= wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  // Next-state logic: MEM priority, flush only ever cuts short a fetch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_mem)     state_d = mem_we ? MEM_WR : MEM_RD;
        else if (grant_if) state_d = IF_RD;
      end
      IF_RD:   if (branch_flush_i || rd_last) state_d = IDLE;
      MEM_RD:  if (rd_last) state_d = IDLE;
      MEM_WR:  if (wr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath/output next values: latch on grant, step address, gather bytes.
  always_comb begin
    cnt_d       = cnt_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    dout_d      = dout_q;
    wr_d        = 1'b0;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_mem) begin
          addr_d  = mem_addr;
          len_d   = mem_len;
          wdata_d = mem_wdata;
          cnt_d   = '0;
          buf_d   = '0;
          if (mem_we) begin
            wr_d   = 1'b1;
            dout_d = mem_wdata[7:0];
          end
        end else if (grant_if) begin
          addr_d = if_addr;
          len_d  = 3'd4;
          cnt_d  = '0;
          buf_d  = '0;
        end
      end
      IF_RD, MEM_RD: begin
        // RAM data lags its address by one cycle, so byte cnt-1 arrives now.
        for (int b = 0; b < 4; b++) begin
          if (cnt_q == 3'(b + 1)) buf_d[8*b +: 8] = ram_din_i;
        end
        if (rd_last) begin
          if (state_q == IF_RD) begin
            if (!branch_flush_i) begin
              if_done_d = 1'b1;
              if_data_d = buf_d;
            end
          end else begin
            mem_done_d  = 1'b1;
            mem_rdata_d = buf_d;
          end
        end else begin
          cnt_d = cnt_inc;
          if (cnt_q < len_q - 3'd1) addr_d = addr_q + ADDR_W'(1);
        end
      end
      MEM_WR: begin
        if (wr_last) begin
          mem_done_d = 1'b1;
        end else begin
          cnt_d  = cnt_inc;
          addr_d = addr_q + ADDR_W'(1);
          wr_d   = 1'b1;
          dout_d = wbyte[cnt_inc[1:0]];
        end
      end
      default: ;
    endcase
  end

  assign ram_addr_o  = addr_q;
  assign ram_dout_o  = dout_q;
  assign ram_wr_o    = wr_q;
  assign if_done     = if_done_q;
  assign mem_done    = mem_done_q;
  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign stall_if_o  = if_req && !if_done_q;
  assign stall_mem_o = mem_req && !mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests for mem_arbiter against a transaction-level
// model (grant rules, per-access timeline, shadow memory) plus literal checks.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data_o;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [1:0]  mem_size = '0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata_o;
  logic        mem_done;
  logic        branch_flush_i = 1'b0;
  logic        stall_if_o, stall_mem_o;
  logic [31:0] ram_addr_o;
  logic [7:0]  ram_dout_o;
  logic        ram_wr_o;
  logic [7:0]  ram_din_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data_o(if_data_o), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata_o(mem_rdata_o), .mem_done(mem_done),
    .branch_flush_i(branch_flush_i), .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
    .ram_addr_o(ram_addr_o), .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
    .ram_din_i(ram_din_i)
  );

  // Preload image; the test addresses are distinct in their low 16 bits.
  logic [31:0] pl_a [16] = '{32'h100, 32'h101, 32'h102, 32'h103,
                             32'h200, 32'h201, 32'h202, 32'h203,
                             32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1,
                             32'h3000, 32'h3001, 32'h3002, 32'h3003};
  logic [7:0]  pl_d [16] = '{8'h13, 8'h05, 8'h50, 8'h00,
                             8'h78, 8'h56, 8'h34, 8'h12,
                             8'h5A, 8'hA5, 8'h11, 8'h22,
                             8'h77, 8'h77, 8'h77, 8'h77};

  logic [7:0] ram    [65536];
  logic [7:0] shadow [65536];
  logic       ram_init = 1'b0;

  // Synchronous RAM: data for an address appears the cycle after it.
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 16; i++) ram[pl_a[i][15:0]] <= pl_d[i];
      ram_init <= 1'b1;
    end else if (ram_wr_o === 1'b1) begin
      ram[ram_addr_o[15:0]] <= ram_dout_o;
    end
    ram_din_i <= ram[ram_addr_o[15:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model state: active access kind (0 none, 1 fetch, 2 load, 3 store).
  int          m_act = 0;
  int          m_s = 0;
  int          m_n = 0;
  int          m_rel;
  bit          m_rst_prev = 1'b1;
  bit          m_started_idle;
  logic [31:0] m_base = '0;
  logic [31:0] m_wd = '0;
  logic [31:0] m_exp;
  logic [31:0] m_ea;
  logic        e_wr, e_ifd, e_md;

  // Model and compare process, evaluated mid-cycle on the falling edge.
  initial begin
    for (int i = 0; i < 16; i++) shadow[pl_a[i][15:0]] = pl_d[i];
    @(posedge clk);
    forever begin
      @(negedge clk);
      m_rel = cyc - m_s;
      e_wr = 1'b0;
      e_ifd = 1'b0;
      e_md = 1'b0;
      if (m_rst_prev) begin
        chk("rst_addr", ram_addr_o, 32'h0);
        chk("rst_dout", 32'(ram_dout_o), 32'h0);
        chk("rst_wr", 32'(ram_wr_o), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_mem_done", 32'(mem_done), 32'h0);
        chk("rst_if_data", if_data_o, 32'h0);
        chk("rst_mem_rdata", mem_rdata_o, 32'h0);
      end else begin
        if ((m_act == 1 || m_act == 2) && m_rel >= 1 && m_rel <= m_n) begin
          m_ea = m_base + 32'(m_rel) - 32'd1;
          chk("rd_addr", ram_addr_o, m_ea);
        end
        if ((m_act == 1 || m_act == 2) && m_rel == m_n + 2) begin
          m_exp = '0;
          for (int k = 0; k < m_n; k++) begin
            m_ea = m_base + 32'(k);
            m_exp[8*k +: 8] = shadow[m_ea[15:0]];
          end
          if (m_act == 1) begin
            e_ifd = 1'b1;
            chk("if_data", if_data_o, m_exp);
          end else begin
            e_md = 1'b1;
            chk("mem_rdata", mem_rdata_o, m_exp);
          end
        end
        if (m_act == 3 && m_rel >= 1 && m_rel <= m_n) begin
          e_wr = 1'b1;
          m_ea = m_base + 32'(m_rel) - 32'd1;
          chk("wr_addr", ram_addr_o, m_ea);
          chk("wr_byte", 32'(ram_dout_o), 32'(m_wd[8*(m_rel-1) +: 8]));
          shadow[m_ea[15:0]] = m_wd[8*(m_rel-1) +: 8];
        end
        if (m_act == 3 && m_rel == m_n + 1) e_md = 1'b1;
        chk("ram_wr", 32'(ram_wr_o), 32'(e_wr));
        chk("if_done", 32'(if_done), 32'(e_ifd));
        chk("mem_done", 32'(mem_done), 32'(e_md));
      end
      chk("stall_if", 32'(stall_if_o), 32'(if_req && !e_ifd));
      chk("stall_mem", 32'(stall_mem_o), 32'(mem_req && !e_md));
      // Advance the model to the next cycle.
      m_started_idle = (m_act == 0);
      if ((m_act == 1 || m_act == 2) && m_rel == m_n + 2) m_act = 0;
      else if (m_act == 3 && m_rel == m_n + 1)          m_act = 0;
      else if (m_act == 1 && branch_flush_i && m_rel >= 1) m_act = 0;
      if (rst !== 1'b1) begin
        m_act = 0;
        m_rst_prev = 1'b1;
      end else begin
        m_rst_prev = 1'b0;
        if (m_started_idle) begin
          if (mem_req) begin
            m_act  = mem_we ? 3 : 2;
            m_s    = cyc;
            m_base = mem_addr;
            m_wd   = mem_wdata;
            m_n    = (mem_size == 2'd0) ? 1 : (mem_size == 2'd1) ? 2 : 4;
          end else if (if_req && !branch_flush_i) begin
            m_act  = 1;
            m_s    = cyc;
            m_base = if_addr;
            m_n    = 4;
          end
        end
      end
    end
  end

  // Issue one request, optionally pulse flush at a given relative cycle.
  task automatic run_txn(input bit is_mem, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int flush_rel, input logic [31:0] new_addr,
                         output int rel, output logic [31:0] data);
    int c0;
    c0 = cyc;
    rel = -1;
    data = '0;
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    for (int i = 0; i < 40 && rel < 0; i++) begin
      @(negedge clk);
      if (is_mem && mem_done === 1'b1) begin rel = cyc - c0; data = mem_rdata_o; end
      if (!is_mem && if_done === 1'b1) begin rel = cyc - c0; data = if_data_o; end
      @(posedge clk); #1;
      branch_flush_i = (flush_rel >= 0) && (cyc - c0 == flush_rel);
      if (!is_mem && flush_rel >= 0 && (cyc - c0 == flush_rel + 1)) if_addr = new_addr;
    end
    mem_req = 1'b0;
    if_req = 1'b0;
    branch_flush_i = 1'b0;
    if (rel < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL txn_timeout: got no done expected done for addr %h", addr);
    end
  endtask

  int          rel, mrel, irel, c0;
  logic [31:0] data, mdata, idata;

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_wr", 32'(ram_wr_o), 32'h0);
    chk("lit_rst_if_done", 32'(if_done), 32'h0);
    chk("lit_rst_addr", ram_addr_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Fetch at 0x100.
    run_txn(1'b0, 1'b0, 2'd0, 32'h100, 32'h0, -1, 32'h0, rel, data);
    chk("lit_fetch_cycle", 32'(rel), 32'd6);
    chk("lit_fetch_data", data, 32'h0050_0513);

    // Store word then load half.
    run_txn(1'b1, 1'b1, 2'd2, 32'h1000, 32'hDEAD_BEEF, -1, 32'h0, rel, data);
    chk("lit_store_cycle", 32'(rel), 32'd5);
    chk("lit_store_b0", 32'(ram[16'h1000]), 32'hEF);
    chk("lit_store_b3", 32'(ram[16'h1003]), 32'hDE);
    run_txn(1'b1, 1'b0, 2'd1, 32'h1002, 32'h0, -1, 32'h0, rel, data);
    chk("lit_ldh_cycle", 32'(rel), 32'd4);
    chk("lit_ldh_data", data, 32'h0000_DEAD);

    // Simultaneous requests: MEM first, IF after the dead cycle.
    c0 = cyc;
    mrel = -1; irel = -1; mdata = '0; idata = '0;
    mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h1000;
    if_req = 1'b1; if_addr = 32'h100;
    for (int i = 0; i < 40 && irel < 0; i++) begin
      @(negedge clk);
      if (mem_done === 1'b1 && mrel < 0) begin mrel = cyc - c0; mdata = mem_rdata_o; end
      if (if_done === 1'b1) begin irel = cyc - c0; idata = if_data_o; end
      @(posedge clk); #1;
      if (mrel >= 0) mem_req = 1'b0;
    end
    mem_req = 1'b0;
    if_req = 1'b0;
    chk("lit_both_mem_cycle", 32'(mrel), 32'd3);
    chk("lit_both_mem_data", mdata, 32'h0000_00EF);
    chk("lit_both_if_cycle", 32'(irel), 32'd10);
    chk("lit_both_if_data", idata, 32'h0050_0513);

    // Flush during a fetch, refetch from 0x200; flush during a load is ignored.
    run_txn(1'b0, 1'b0, 2'd0, 32'h100, 32'h0, 3, 32'h200, rel, data);
    chk("lit_flush_if_cycle", 32'(rel), 32'd10);
    chk("lit_flush_if_data", data, 32'h1234_5678);
    run_txn(1'b1, 1'b0, 2'd2, 32'h1000, 32'h0, 3, 32'h0, rel, data);
    chk("lit_flush_mem_cycle", 32'(rel), 32'd6);
    chk("lit_flush_mem_data", data, 32'hDEAD_BEEF);

    // Address wrap at the top of the address space.
    run_txn(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h0, -1, 32'h0, rel, data);
    chk("lit_wrap_byte_cycle", 32'(rel), 32'd3);
    chk("lit_wrap_byte_data", data, 32'h0000_00A5);
    run_txn(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFE, 32'h0, -1, 32'h0, rel, data);
    chk("lit_wrap_word_cycle", 32'(rel), 32'd6);
    chk("lit_wrap_word_data", data, 32'h2211_A55A);

    // Reset during the second byte of a word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd2; mem_addr = 32'h3000;
    mem_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    mem_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("lit_midrst_wr", 32'(ram_wr_o), 32'h0);
    @(posedge clk); #1;
    chk("lit_midrst_b0", 32'(ram[16'h3000]), 32'h0D);
    chk("lit_midrst_b1", 32'(ram[16'h3001]), 32'hF0);
    chk("lit_midrst_b2", 32'(ram[16'h3002]), 32'h77);
    chk("lit_midrst_b3", 32'(ram[16'h3003]), 32'h77);
    run_txn(1'b1, 1'b0, 2'd2, 32'h3000, 32'h0, -1, 32'h0, rel, data);
    chk("lit_midrst_load", data, 32'h7777_F00D);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
